// File: rtl/four_input_nor_tester_pkg.sv
// Purpose: shared types, constants and the NOR reference function for the 4-input NOR tester.
// Latency: none (declarations only).
// Backpressure: none.
package four_nor_pkg;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;

    typedef logic [VEC_W-1:0] vec_t;

    // Binary-encoded tester states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Expected output of a healthy 4-input NOR for the given input vector.
    function automatic logic nor4_expected(input vec_t vec);
        return ~(vec[3] | vec[2] | vec[1] | vec[0]);
    endfunction

endpackage

// File: rtl/four_input_nor_tester_if.sv
// Purpose: bundles the tester's control, gate-drive and result signals.
// Latency: none (wires only).
// Backpressure: none; start is a level, results are held until the next run.
interface four_input_nor_tester_if;
    import four_nor_pkg::*;

    logic       start;
    logic       e_in;
    logic       a_out;
    logic       b_out;
    logic       c_out;
    logic       d_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       fail_valid;
    vec_t       first_fail_vec;

    // Tester side: drives the gate inputs and reports results.
    modport master (
        input  start,
        input  e_in,
        output a_out,
        output b_out,
        output c_out,
        output d_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_valid,
        output first_fail_vec
    );

    // Board side: requests runs, closes the loop through the gate, reads results.
    modport slave (
        output start,
        output e_in,
        input  a_out,
        input  b_out,
        input  c_out,
        input  d_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_valid,
        input  first_fail_vec
    );

endinterface

// File: rtl/four_input_nor_tester.sv
// Purpose: walks all 16 NOR input vectors, samples E after a settle delay, tallies mismatches.
// Latency: SETTLE_CYCLES+2 cycles per vector, 16*(SETTLE_CYCLES+2) from start accept to DONE.
// Backpressure: start is only honoured in IDLE/DONE; requests while busy are ignored.
module four_input_nor_tester
    import four_nor_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    four_input_nor_tester_if.master bus
);

    // Last WAIT count value; unused when there is no settle phase.
    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam vec_t       VEC_LAST    = vec_t'(NUM_VEC - 1);
    localparam bit         HAS_WAIT    = (SETTLE_CYCLES > 0);

    state_e     state_q;
    vec_t       vec_q;
    logic [3:0] cnt_q;
    logic [4:0] err_q;
    logic       fail_vld_q;
    vec_t       first_fail_q;

    // Sequencer: vector walk, settle timing and result accumulation in one registered FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            fail_vld_q   <= 1'b0;
            first_fail_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // A new run wipes the previous results on the accept edge.
                    if (bus.start) begin
                        state_q      <= ST_APPLY;
                        vec_q        <= '0;
                        err_q        <= '0;
                        fail_vld_q   <= 1'b0;
                        first_fail_q <= '0;
                    end
                end
                ST_APPLY: begin
                    cnt_q   <= '0;
                    state_q <= HAS_WAIT ? ST_WAIT : ST_SAMPLE;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (bus.e_in != nor4_expected(vec_q)) begin
                        err_q <= err_q + 5'd1;
                        if (!fail_vld_q) begin
                            fail_vld_q   <= 1'b1;
                            first_fail_q <= vec_q;
                        end
                    end
                    // Vector 15 is terminal: it stays on the gate inputs through DONE.
                    if (vec_q == VEC_LAST) begin
                        state_q <= ST_DONE;
                    end else begin
                        vec_q   <= vec_q + vec_t'(1);
                        state_q <= ST_APPLY;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only.
    assign bus.a_out          = vec_q[3];
    assign bus.b_out          = vec_q[2];
    assign bus.c_out          = vec_q[1];
    assign bus.d_out          = vec_q[0];
    assign bus.busy           = (state_q == ST_APPLY) || (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.pass           = (state_q == ST_DONE) && (err_q == 5'd0);
    assign bus.err_count      = err_q;
    assign bus.fail_valid     = fail_vld_q;
    assign bus.first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_four_input_nor_tester.sv
// Purpose: randomized scoreboard bench for the NOR tester with a table-driven gate model on E.
// Latency: expects 16*(SETTLE_CYCLES+2) busy cycles per run.
// Backpressure: start requests issued while busy are expected to be ignored.
module tb_four_input_nor_tester;
    import four_nor_pkg::*;

    localparam int S0 = 2;
    localparam int SZ = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    four_input_nor_tester_if if0 ();
    four_input_nor_tester_if ifz ();

    four_input_nor_tester #(.SETTLE_CYCLES(S0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.master)
    );

    four_input_nor_tester #(.SETTLE_CYCLES(SZ)) dutz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifz.master)
    );

    // Gate under test: bit v of the table is E when the inputs read v.
    logic [15:0] tbl0 = 16'h0001;
    logic [15:0] tblz = 16'hFFFE;

    assign if0.e_in = tbl0[{if0.a_out, if0.b_out, if0.c_out, if0.d_out}];
    assign ifz.e_in = tblz[{ifz.a_out, ifz.b_out, ifz.c_out, ifz.d_out}];

    typedef struct {
        int err;
        int fv;
        int ffv;
        int pass;
    } res_t;

    res_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: a healthy NOR is 1 only for the all-zero vector.
    function automatic res_t model(input logic [15:0] tbl);
        res_t r;
        r.err = 0;
        r.fv  = 0;
        r.ffv = 0;
        for (int v = 0; v < 16; v++) begin
            if (int'(tbl[v]) != ((v == 0) ? 1 : 0)) begin
                if (r.fv == 0) begin
                    r.fv  = 1;
                    r.ffv = v;
                end
                r.err++;
            end
        end
        r.pass = (r.err == 0) ? 1 : 0;
        return r;
    endfunction

    function automatic int outs(input int sel);
        if (sel == 0)
            return int'({if0.a_out, if0.b_out, if0.c_out, if0.d_out, if0.busy, if0.done, if0.pass,
                         if0.err_count, if0.fail_valid, if0.first_fail_vec});
        return int'({ifz.a_out, ifz.b_out, ifz.c_out, ifz.d_out, ifz.busy, ifz.done, ifz.pass,
                     ifz.err_count, ifz.fail_valid, ifz.first_fail_vec});
    endfunction

    // Monitor: on each DONE entry pop the expected run result and compare.
    int busy_cyc = 0;
    bit busy_p   = 1'b0;
    bit done_p   = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cyc = 0;
            busy_p   = 1'b0;
            done_p   = 1'b0;
        end else begin
            if (if0.busy) busy_cyc = busy_p ? busy_cyc + 1 : 1;
            if (if0.done && !done_p) begin
                check("sb_has_entry", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    res_t e;
                    e = sb_q.pop_front();
                    check("err_count", int'(if0.err_count), e.err);
                    check("fail_valid", int'(if0.fail_valid), e.fv);
                    check("first_fail_vec", int'(if0.first_fail_vec), e.ffv);
                    check("pass", int'(if0.pass), e.pass);
                    check("busy_cycles", busy_cyc, 16 * (S0 + 2));
                    check("vec_at_done", int'({if0.a_out, if0.b_out, if0.c_out, if0.d_out}), 15);
                end
            end
            busy_p = if0.busy;
            done_p = if0.done;
        end
    end

    task automatic pulse_start0();
        @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    task automatic wait_done0(input string nm);
        int k = 0;
        while (!if0.done && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(nm, int'(if0.done), 1);
    endtask

    task automatic run0(input logic [15:0] tbl, input string nm);
        tbl0 = tbl;
        sb_q.push_back(model(tbl));
        pulse_start0();
        wait_done0(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        res_t m;
        int   c;
        if0.start = 1'b0;
        ifz.start = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_outs_dut0", outs(0), 0);
        check("reset_outs_dutz", outs(1), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_run", int'(if0.busy | if0.done), 0);

        // Directed gate behaviours.
        run0(16'h0001, "done_real_nor");
        repeat (3) @(negedge clk);
        check("done_holds", int'(if0.done), 1);
        check("pass_holds", int'(if0.pass), 1);
        run0(16'h0000, "done_stuck0");
        run0(16'hFFFF, "done_stuck1");
        run0(16'hFFFE, "done_inverted");

        // Randomized faulty gates.
        for (int i = 0; i < 5; i++) begin
            run0(16'($urandom), "done_random");
        end

        // Asynchronous reset while vector 7 settles.
        tbl0 = 16'($urandom);
        sb_q.push_back(model(tbl0));
        pulse_start0();
        c = 0;
        while ({if0.a_out, if0.b_out, if0.c_out, if0.d_out} != 4'd7 && c < 400) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        check("busy_at_vec7", int'(if0.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_outs", outs(0), 0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", int'(if0.busy | if0.done), 0);

        // Start pulse during a run must not disturb it.
        tbl0 = 16'($urandom);
        m = model(tbl0);
        sb_q.push_back(m);
        pulse_start0();
        repeat (20) @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        wait_done0("done_spurious_start");
        repeat (3) @(negedge clk);
        check("no_restart_after_done", int'(if0.done), 1);
        check("err_hold", int'(if0.err_count), m.err);

        // Start held high across DONE: one-cycle done, identical second run.
        tbl0 = 16'($urandom);
        m = model(tbl0);
        sb_q.push_back(m);
        sb_q.push_back(m);
        @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        wait_done0("done_held_first");
        @(negedge clk);
        check("done_one_cycle", int'(if0.done), 0);
        check("restart_busy", int'(if0.busy), 1);
        check("restart_cleared", int'(if0.err_count), 0);
        if0.start = 1'b0;
        wait_done0("done_held_second");

        // Zero-settle build against an inverted gate.
        @(negedge clk);
        ifz.start = 1'b1;
        @(negedge clk);
        ifz.start = 1'b0;
        c = 0;
        for (int k = 0; k < 100 && !ifz.done; k++) begin
            if (ifz.busy) c++;
            @(negedge clk);
        end
        m = model(tblz);
        check("z_done", int'(ifz.done), 1);
        check("z_busy_cycles", c, 16 * (SZ + 2));
        check("z_err_count", int'(ifz.err_count), m.err);
        check("z_first_fail", int'(ifz.first_fail_vec), m.ffv);
        check("z_fail_valid", int'(ifz.fail_valid), m.fv);
        check("z_pass", int'(ifz.pass), m.pass);

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/four_input_nor_tester.md
Name: four_input_nor_tester

Overview:
- Sequential stimulus generator and response checker for the 4-input NOR gate: the driving end of the gate's A/B/C/D → E interface.
- Applies all 16 input vectors in ascending order and samples the gate output after a programmable settle delay.
- Compares each sample against the expected NOR result and reports error count, first failing vector, and pass/fail.
- Sits on the lab board top level between the switch/button logic and the gate under test.

Parameters:
- SETTLE_CYCLES, 2, number of clk cycles held between applying a vector and sampling e_in; legal range 0..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level; sampled in IDLE or DONE to begin a run
- e_in  input  1  gate-under-test output E
- a_out  output  1  gate input A = vec[3]
- b_out  output  1  gate input B = vec[2]
- c_out  output  1  gate input C = vec[1]
- d_out  output  1  gate input D = vec[0]
- busy  output  1  high in APPLY/WAIT/SAMPLE
- done  output  1  high in DONE
- pass  output  1  high in DONE when err_count==0
- err_count  output  5  number of mismatching vectors, 0..16
- fail_valid  output  1  a mismatch has been recorded this run
- first_fail_vec  output  4  vec of first mismatch; valid when fail_valid

Behaviour:
- Interface rules:
  - Reset is asynchronous and active-low. One clock domain (clk). No synchronisers; e_in is assumed stable by the sample cycle.
  - Reset values: all outputs 0. Internally vec=0, settle counter=0, state=IDLE.
- FSM states: IDLE, APPLY, WAIT, SAMPLE, DONE.
- IDLE:
  - a..d_out driven from vec (0).
  - start=1 → APPLY. vec←0, err_count←0, fail_valid←0, first_fail_vec←0.
- APPLY (1 cycle):
  - vec is driven on a..d_out (combinational from the vec register).
  - Settle counter←0.
  - Next state is WAIT if SETTLE_CYCLES>0, otherwise SAMPLE.
- WAIT:
  - Counter increments each cycle.
  - After SETTLE_CYCLES cycles in WAIT → SAMPLE.
- SAMPLE (1 cycle):
  - expected = ~(vec[3]|vec[2]|vec[1]|vec[0]), i.e. 1 only for vec=0.
  - On e_in≠expected: err_count+1. If fail_valid==0, first_fail_vec←vec and fail_valid←1.
  - If vec==15 → DONE. Else vec←vec+1 and → APPLY.
- DONE:
  - done=1; pass=(err_count==0); vec holds 15 on the outputs.
  - Results hold until the next start.
  - start=1 in DONE restarts exactly as from IDLE; done, pass, and the result fields clear on entry to APPLY.
- Timing:
  - Per vector: SETTLE_CYCLES+2 cycles. Full run: 16×(SETTLE_CYCLES+2) cycles from the start-accept edge to DONE entry (64 at default).
  - Outputs are registered or decoded from registered state only.
- Boundaries:
  - start while busy: ignored.
  - start held high continuously: a new run begins on the cycle after DONE is entered (done high for exactly 1 cycle).
  - vec does not wrap; 15 is terminal.
  - err_count max is 16 and fits in 5 bits; no saturation logic.
  - rst_n asserted mid-run: immediate return to reset values, IDLE, no partial results retained.

Decomposition:
- Shared package four_nor_pkg:
  - state enum (IDLE/APPLY/WAIT/SAMPLE/DONE, binary encoded)
  - VEC_W=4 and NUM_VEC=16 constants
  - nor4_expected(vec) function, used by both RTL and bench
- No sub-module required; the settle counter and vec counter stay inline.

Test Plan:
- Real NOR gate on e_in, default parameter, start pulse at cycle 0 → busy for 64 cycles, done=1; pass=1, err_count=0, fail_valid=0.
- e_in stuck-at-0 → err_count=1, first_fail_vec=0, fail_valid=1, pass=0.
- e_in stuck-at-1 → err_count=15, first_fail_vec=1, pass=0.
- e_in = OR of the outputs (inverted gate) → err_count=16, first_fail_vec=0; SETTLE_CYCLES=0 build completes in 32 cycles.
- rst_n low during vec=7 WAIT → all outputs 0 asynchronously, IDLE; a start pulse while busy during a later run has no effect on the sequence or counts.
- start held high through DONE → done high 1 cycle, second run restarts with cleared counters and produces identical results.
